// File: rtl/rotary_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rotary_pkg
// Description : Shared constants for the rotary quadrature counter: LED display
//               modes, step directions, FSM state encoding and counter widths.
// Revision    : 1.0 - initial release
// ============================================================================
package rotary_pkg;

  // LED display modes
  localparam logic LED_BIN    = 1'b0;
  localparam logic LED_ONEHOT = 1'b1;

  // Step directions (reported on dir)
  localparam logic DIR_CW  = 1'b0;
  localparam logic DIR_CCW = 1'b1;

  // Control FSM state encoding
  localparam logic [0:0] ST_INIT = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  // Debounce stability counter width (FILT_LEN is at most 255)
  localparam int FILT_CNT_W = 8;

  // INIT duration counter width (2+FILT_LEN is at most 257)
  localparam int INIT_CNT_W = 9;

endpackage
`default_nettype wire

// File: rtl/rotary_quad_counter_if.sv
`default_nettype none
// ============================================================================
// Module      : rotary_quad_counter_if
// Description : Encoder pins, controls and LED/count outputs of the rotary
//               quadrature counter. master = board/driver side, slave = counter.
// Revision    : 1.0 - initial release
// ============================================================================
interface rotary_quad_counter_if #(
  parameter int CNT_W   = 8,
  parameter int NUM_LED = 8
);
  logic               rot_a;
  logic               rot_b;
  logic               en;
  logic               clr;
  logic               led_mode;
  logic [CNT_W-1:0]   count;
  logic               step;
  logic               dir;
  logic               limit;
  logic [NUM_LED-1:0] led;

  modport master (
    output rot_a, rot_b, en, clr, led_mode,
    input  count, step, dir, limit, led
  );

  modport slave (
    input  rot_a, rot_b, en, clr, led_mode,
    output count, step, dir, limit, led
  );
endinterface
`default_nettype wire

// File: rtl/rotary_filter.sv
`default_nettype none
// ============================================================================
// Module      : rotary_filter
// Description : Two-flop synchroniser plus stability-count debounce for one
//               encoder channel. While init is high the filtered output
//               tracks the synchronised input directly.
// Revision    : 1.0 - initial release
// ============================================================================
module rotary_filter
  import rotary_pkg::*;
#(
  parameter int FILT_LEN = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  input  logic init,
  output logic q
);

  // With FILT_LEN=1 the filter loads on the first cycle s2 differs; otherwise
  // it loads when the counter, started one cycle after s2 settled, hits
  // FILT_LEN-2 (so f changes FILT_LEN cycles after s2).
  localparam bit                    C_SINGLE  = (FILT_LEN <= 1);
  localparam logic [FILT_CNT_W-1:0] C_LOAD_AT = FILT_CNT_W'((FILT_LEN > 1) ? FILT_LEN - 2 : 0);

  logic                  s1_q, s1_d;
  logic                  s2_q, s2_d;
  logic                  s2p_q, s2p_d;
  logic                  f_q, f_d;
  logic [FILT_CNT_W-1:0] cnt_q, cnt_d;
  logic                  changed;

  // Register stage: synchroniser, change detector, filtered value and counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q  <= 1'b0;
      s2_q  <= 1'b0;
      s2p_q <= 1'b0;
      f_q   <= 1'b0;
      cnt_q <= '0;
    end else begin
      s1_q  <= s1_d;
      s2_q  <= s2_d;
      s2p_q <= s2p_d;
      f_q   <= f_d;
      cnt_q <= cnt_d;
    end
  end

  // Next-state: count stable cycles of a differing input, load f at the end
  always_comb begin
    s1_d    = d;
    s2_d    = s1_q;
    s2p_d   = s2_q;
    changed = (s2_q != s2p_q);
    f_d     = f_q;
    cnt_d   = '0;
    if (init) begin
      f_d = s2_q;
    end else if (s2_q != f_q) begin
      if (C_SINGLE || (!changed && (cnt_q == C_LOAD_AT))) begin
        f_d = s2_q;
      end else if (!changed) begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  assign q = f_q;

endmodule
`default_nettype wire

// File: rtl/rotary_quad_counter.sv
`default_nettype none
// ============================================================================
// Module      : rotary_quad_counter
// Description : Debounced rotary-encoder detent decoder driving a wrap or
//               saturate position counter and a binary/one-hot LED bank.
// Revision    : 1.0 - initial release
// ============================================================================
module rotary_quad_counter
  import rotary_pkg::*;
#(
  parameter int CNT_W    = 8,
  parameter int FILT_LEN = 4,
  parameter int STEP     = 1,
  parameter int WRAP     = 1,
  parameter int NUM_LED  = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  rotary_quad_counter_if.slave   bus
);

  localparam logic [INIT_CNT_W-1:0] C_INIT_LAST = INIT_CNT_W'(FILT_LEN + 1);
  localparam logic [CNT_W:0]        C_STEP      = (CNT_W + 1)'(STEP);
  localparam bit                    C_WRAP      = (WRAP != 0);

  logic [0:0]            st_q, st_d;
  logic [INIT_CNT_W-1:0] init_cnt_q, init_cnt_d;
  logic                  init_mode, run_mode;

  logic                  f_a, f_b;
  logic                  fa_prev_q, fa_prev_d;
  logic                  step_q, step_d;
  logic                  dir_q, dir_d;
  logic                  limit_q, limit_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic [NUM_LED-1:0]    led_q, led_d;
  logic                  fresh_q, fresh_d;

  logic [CNT_W:0]        sum_w, diff_w;
  logic [31:0]           led_idx;

  rotary_filter #(.FILT_LEN(FILT_LEN)) u_filt_a (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (bus.rot_a),
    .init  (init_mode),
    .q     (f_a)
  );

  rotary_filter #(.FILT_LEN(FILT_LEN)) u_filt_b (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (bus.rot_b),
    .init  (init_mode),
    .q     (f_b)
  );

  // FSM state register with the INIT duration counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q       <= ST_INIT;
      init_cnt_q <= '0;
    end else begin
      st_q       <= st_d;
      init_cnt_q <= init_cnt_d;
    end
  end

  // FSM next state: hold INIT for 2+FILT_LEN cycles, then RUN until reset
  always_comb begin
    st_d       = st_q;
    init_cnt_d = init_cnt_q;
    case (st_q)
      ST_INIT: begin
        init_cnt_d = init_cnt_q + 1'b1;
        if (init_cnt_q == C_INIT_LAST) begin
          st_d = ST_RUN;
        end
      end
      default: st_d = ST_RUN;
    endcase
  end

  // FSM outputs: filters track raw inputs in INIT, decoding only in RUN
  always_comb begin
    init_mode = (st_q == ST_INIT);
    run_mode  = (st_q == ST_RUN);
  end

  // Datapath registers: edge detector, step/dir/limit, count and LEDs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fa_prev_q <= 1'b0;
      step_q    <= 1'b0;
      dir_q     <= DIR_CW;
      limit_q   <= 1'b0;
      count_q   <= '0;
      led_q     <= '0;
      fresh_q   <= 1'b1;
    end else begin
      fa_prev_q <= fa_prev_d;
      step_q    <= step_d;
      dir_q     <= dir_d;
      limit_q   <= limit_d;
      count_q   <= count_d;
      led_q     <= led_d;
      fresh_q   <= fresh_d;
    end
  end

  // Decode a detent on f_a rising and compute the next count, limit and LEDs
  always_comb begin
    fa_prev_d = f_a;
    fresh_d   = 1'b0;
    step_d    = run_mode && f_a && !fa_prev_q;
    dir_d     = step_d ? f_b : dir_q;
    sum_w     = {1'b0, count_q} + C_STEP;
    diff_w    = {1'b0, count_q} - C_STEP;
    count_d   = count_q;
    limit_d   = 1'b0;
    if (bus.clr) begin
      count_d = '0;
    end else if (step_d && bus.en) begin
      if (f_b == DIR_CW) begin
        count_d = sum_w[CNT_W-1:0];
        if (sum_w[CNT_W]) begin
          limit_d = 1'b1;
          if (!C_WRAP) count_d = '1;
        end
      end else begin
        count_d = diff_w[CNT_W-1:0];
        if (diff_w[CNT_W]) begin
          limit_d = 1'b1;
          if (!C_WRAP) count_d = '0;
        end
      end
    end
    led_idx = 32'(count_d) % 32'(NUM_LED);
    if (bus.led_mode == LED_ONEHOT) begin
      led_d = NUM_LED'(1) << led_idx;
    end else begin
      led_d = NUM_LED'(count_d);
    end
  end

  // Until the first edge after reset the LED register has not seen led_mode,
  // so the reset display (all off / LED 0 lit) is chosen directly from it.
  assign bus.led   = fresh_q ? ((bus.led_mode == LED_ONEHOT) ? NUM_LED'(1) : '0) : led_q;
  assign bus.count = count_q;
  assign bus.step  = step_q;
  assign bus.dir   = dir_q;
  assign bus.limit = limit_q;

endmodule
`default_nettype wire

// File: tb/tb_rotary_quad_counter.sv
`default_nettype none
// ============================================================================
// Module      : tb_rotary_quad_counter
// Description : Self-checking bench. dut0 uses defaults (8-bit wrap, step 1);
//               dut1 is a 4-bit saturating counter with STEP=4. Both share the
//               same encoder and control stimulus.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rotary_quad_counter;

  typedef struct {
    logic       b;
    logic       en;
    logic       clr;
    logic       mode;
    logic [7:0] c0;
    logic       l0;
    logic [7:0] led0;
    logic [3:0] c1;
    logic       l1;
    logic [3:0] led1;
  } vec_t;

  localparam int NVEC = 28;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rot_a = 1'b0, rot_b = 1'b0, en = 1'b1, clr = 1'b0, led_mode = 1'b0;
  int   n_checks = 0;
  int   n_err = 0;
  vec_t tbl [NVEC];

  rotary_quad_counter_if #(.CNT_W(8), .NUM_LED(8)) if0 ();
  rotary_quad_counter_if #(.CNT_W(4), .NUM_LED(4)) if1 ();

  assign if0.rot_a = rot_a;  assign if1.rot_a = rot_a;
  assign if0.rot_b = rot_b;  assign if1.rot_b = rot_b;
  assign if0.en = en;        assign if1.en = en;
  assign if0.clr = clr;      assign if1.clr = clr;
  assign if0.led_mode = led_mode;
  assign if1.led_mode = led_mode;

  rotary_quad_counter dut0 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if0.slave)
  );

  rotary_quad_counter #(.CNT_W(4), .FILT_LEN(4), .STEP(4), .WRAP(0), .NUM_LED(4)) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if1.slave)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input logic b, input logic e, input logic c, input logic m,
                              input logic [7:0] c0, input logic l0, input logic [7:0] led0,
                              input logic [3:0] c1, input logic l1, input logic [3:0] led1);
    vec_t v;
    v.b = b; v.en = e; v.clr = c; v.mode = m;
    v.c0 = c0; v.l0 = l0; v.led0 = led0;
    v.c1 = c1; v.l1 = l1; v.led1 = led1;
    return v;
  endfunction

  task automatic chk(input string nm, input int r, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s (row %0d): got %0h, expected %0h", nm, r, act, exp);
    end
  endtask

  // Watch n cycles for step pulses on either DUT
  task automatic quiet(input int n, output int p0, output int p1);
    p0 = 0; p1 = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (if0.step === 1'b1) p0++;
      if (if1.step === 1'b1) p1++;
    end
  endtask

  // One detent from the table: rot_a rises at a negedge before edge k, the
  // step must appear after edge k+6 (sampled at the 7th following negedge).
  task automatic detent(input int r);
    int   p0, p1;
    logic hit0, hit1;
    p0 = 0; p1 = 0; hit0 = 1'b0; hit1 = 1'b0;
    led_mode = tbl[r].mode;
    en       = tbl[r].en;
    rot_b    = tbl[r].b;
    repeat (8) @(negedge clk);
    rot_a = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (if0.step === 1'b1) p0++;
      if (if1.step === 1'b1) p1++;
      if (i == 6) clr = tbl[r].clr;
      if (i == 7) begin
        hit0 = if0.step;
        hit1 = if1.step;
        chk("dir",    r, 32'(if0.dir),   32'(tbl[r].b));
        chk("count0", r, 32'(if0.count), 32'(tbl[r].c0));
        chk("limit0", r, 32'(if0.limit), 32'(tbl[r].l0));
        chk("led0",   r, 32'(if0.led),   32'(tbl[r].led0));
        chk("count1", r, 32'(if1.count), 32'(tbl[r].c1));
        chk("limit1", r, 32'(if1.limit), 32'(tbl[r].l1));
        chk("led1",   r, 32'(if1.led),   32'(tbl[r].led1));
        clr = 1'b0;
      end
      if (i == 10) rot_a = 1'b0;
    end
    chk("step_time0",  r, 32'(hit0), 32'd1);
    chk("step_pulses", r, 32'(p0 + p1), 32'd2);
    en = 1'b1;
  endtask

  initial begin
    int p0, p1;
    //             b     en    clr   mode  c0      l0    led0   c1     l1    led1
    tbl[0]  = mk(1'b0, 1'b1, 1'b0, 1'b0, 8'd1,   1'b0, 8'h01, 4'd4,  1'b0, 4'h4);
    tbl[1]  = mk(1'b1, 1'b1, 1'b0, 1'b0, 8'd0,   1'b0, 8'h00, 4'd0,  1'b0, 4'h0);
    tbl[2]  = mk(1'b1, 1'b1, 1'b0, 1'b0, 8'd255, 1'b1, 8'hFF, 4'd0,  1'b1, 4'h0);
    tbl[3]  = mk(1'b0, 1'b1, 1'b0, 1'b0, 8'd0,   1'b1, 8'h00, 4'd4,  1'b0, 4'h4);
    tbl[4]  = mk(1'b1, 1'b1, 1'b0, 1'b0, 8'd255, 1'b1, 8'hFF, 4'd0,  1'b0, 4'h0);
    tbl[5]  = mk(1'b0, 1'b0, 1'b0, 1'b0, 8'd255, 1'b0, 8'hFF, 4'd0,  1'b0, 4'h0);
    tbl[6]  = mk(1'b1, 1'b0, 1'b0, 1'b0, 8'd255, 1'b0, 8'hFF, 4'd0,  1'b0, 4'h0);
    tbl[7]  = mk(1'b0, 1'b1, 1'b1, 1'b0, 8'd0,   1'b0, 8'h00, 4'd0,  1'b0, 4'h0);
    tbl[8]  = mk(1'b0, 1'b1, 1'b0, 1'b0, 8'd1,   1'b0, 8'h01, 4'd4,  1'b0, 4'h4);
    tbl[9]  = mk(1'b0, 1'b1, 1'b0, 1'b0, 8'd2,   1'b0, 8'h02, 4'd8,  1'b0, 4'h8);
    tbl[10] = mk(1'b0, 1'b1, 1'b0, 1'b0, 8'd3,   1'b0, 8'h03, 4'd12, 1'b0, 4'hC);
    tbl[11] = mk(1'b0, 1'b1, 1'b0, 1'b0, 8'd4,   1'b0, 8'h04, 4'd15, 1'b1, 4'hF);
    tbl[12] = mk(1'b0, 1'b1, 1'b0, 1'b0, 8'd5,   1'b0, 8'h05, 4'd15, 1'b1, 4'hF);
    tbl[13] = mk(1'b1, 1'b1, 1'b0, 1'b0, 8'd4,   1'b0, 8'h04, 4'd11, 1'b0, 4'hB);
    tbl[14] = mk(1'b1, 1'b1, 1'b0, 1'b0, 8'd3,   1'b0, 8'h03, 4'd7,  1'b0, 4'h7);
    tbl[15] = mk(1'b1, 1'b1, 1'b0, 1'b0, 8'd2,   1'b0, 8'h02, 4'd3,  1'b0, 4'h3);
    tbl[16] = mk(1'b1, 1'b1, 1'b0, 1'b0, 8'd1,   1'b0, 8'h01, 4'd0,  1'b1, 4'h0);
    tbl[17] = mk(1'b1, 1'b1, 1'b0, 1'b0, 8'd0,   1'b0, 8'h00, 4'd0,  1'b1, 4'h0);
    tbl[18] = mk(1'b0, 1'b1, 1'b0, 1'b1, 8'd1,   1'b0, 8'h02, 4'd4,  1'b0, 4'h1);
    tbl[19] = mk(1'b0, 1'b1, 1'b0, 1'b1, 8'd2,   1'b0, 8'h04, 4'd8,  1'b0, 4'h1);
    tbl[20] = mk(1'b0, 1'b1, 1'b0, 1'b1, 8'd3,   1'b0, 8'h08, 4'd12, 1'b0, 4'h1);
    tbl[21] = mk(1'b0, 1'b1, 1'b0, 1'b1, 8'd4,   1'b0, 8'h10, 4'd15, 1'b1, 4'h8);
    tbl[22] = mk(1'b0, 1'b1, 1'b0, 1'b1, 8'd5,   1'b0, 8'h20, 4'd15, 1'b1, 4'h8);
    tbl[23] = mk(1'b0, 1'b1, 1'b0, 1'b1, 8'd6,   1'b0, 8'h40, 4'd15, 1'b1, 4'h8);
    tbl[24] = mk(1'b0, 1'b1, 1'b0, 1'b1, 8'd7,   1'b0, 8'h80, 4'd15, 1'b1, 4'h8);
    tbl[25] = mk(1'b0, 1'b1, 1'b0, 1'b1, 8'd8,   1'b0, 8'h01, 4'd15, 1'b1, 4'h8);
    tbl[26] = mk(1'b0, 1'b1, 1'b0, 1'b1, 8'd9,   1'b0, 8'h02, 4'd15, 1'b1, 4'h8);
    tbl[27] = mk(1'b0, 1'b1, 1'b0, 1'b1, 8'd10,  1'b0, 8'h04, 4'd15, 1'b1, 4'h8);

    // Reset state, including reset LED pattern in both display modes
    rst_n = 1'b0; rot_a = 1'b1; rot_b = 1'b1; led_mode = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_count0", -1, 32'(if0.count), 32'd0);
    chk("rst_step0",  -1, 32'(if0.step),  32'd0);
    chk("rst_led0_onehot", -1, 32'(if0.led), 32'h01);
    chk("rst_led1_onehot", -1, 32'(if1.led), 32'h1);
    led_mode = 1'b0;
    #1;
    chk("rst_led0_bin", -1, 32'(if0.led), 32'h00);

    // Release with both channels already high: no step may ever appear
    @(negedge clk);
    rst_n = 1'b1;
    quiet(20, p0, p1);
    chk("init_no_step", -1, 32'(p0 + p1), 32'd0);
    chk("init_count0",  -1, 32'(if0.count), 32'd0);
    chk("init_led0",    -1, 32'(if0.led),   32'h00);
    rot_a = 1'b0; rot_b = 1'b0;
    quiet(12, p0, p1);
    chk("fall_no_step", -1, 32'(p0 + p1), 32'd0);

    for (int r = 0; r < NVEC; r++) detent(r);

    // led_mode change reaches the LEDs on the next edge, not before
    led_mode = 1'b0;
    #1;
    chk("mode_hold_led0", -2, 32'(if0.led), 32'h04);
    @(negedge clk);
    chk("mode_new_led0", -2, 32'(if0.led), 32'h0A);
    chk("mode_new_led1", -2, 32'(if1.led), 32'hF);

    // Glitch of 3 cycles is rejected
    rot_b = 1'b0;
    repeat (8) @(negedge clk);
    rot_a = 1'b1;
    repeat (3) @(negedge clk);
    rot_a = 1'b0;
    quiet(15, p0, p1);
    chk("glitch_no_step", -3, 32'(p0 + p1), 32'd0);
    chk("glitch_count0",  -3, 32'(if0.count), 32'd10);

    // A 4-cycle pulse (exactly FILT_LEN) is accepted as a detent
    rot_a = 1'b1;
    repeat (4) @(negedge clk);
    rot_a = 1'b0;
    quiet(15, p0, p1);
    chk("pulse4_step",   -4, 32'(p0), 32'd1);
    chk("pulse4_count0", -4, 32'(if0.count), 32'd11);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/rotary_quad_counter.md
Name: rotary_quad_counter

Overview:
- Parametrised successor to the lab rotary-shaft event/LED path.
- Synchronises and debounces the two quadrature lines of the rotary shaft, then decodes one step per detent with direction.
- Maintains a CNT_W-bit position counter with wrap or saturate mode, and drives a NUM_LED-wide LED bank in binary or one-hot display mode.
- Sits between the board encoder pins and the LED pins, replacing the fixed 8-LED event/drive pair.

Parameters:
- CNT_W, 8: position counter width (2..16).
- FILT_LEN, 4: cycles a synchronised input must be stable before the filtered value changes (1..255).
- STEP, 1: counter increment/decrement per detent (1..2^(CNT_W-1)).
- WRAP, 1: 1 = modular counter; 0 = saturate at 0 and 2^CNT_W-1.
- NUM_LED, 8: LED output width (1..CNT_W for binary mode).

Ports:
- clk  in  1  system clock; the only clock.
- rst_n  in  1  asynchronous active-low reset.
- rot_a  in  1  encoder channel A, asynchronous to clk.
- rot_b  in  1  encoder channel B, asynchronous to clk.
- en  in  1  1 = steps update count; 0 = steps still reported, count held.
- clr  in  1  synchronous clear of count to 0; takes priority over a step.
- led_mode  in  1  0 = binary count on LEDs; 1 = one-hot on LED index (count mod NUM_LED).
- count  out  CNT_W  current position.
- step  out  1  one-cycle pulse per decoded detent.
- dir  out  1  direction of last step: 0 = CW/increment, 1 = CCW/decrement.
- limit  out  1  one-cycle pulse when a step wraps (WRAP=1) or is clamped (WRAP=0).
- led  out  NUM_LED  LED drive.

Behaviour:
- Reset, asynchronous on rst_n=0: count=0, step=0, dir=0, limit=0. led=0 in binary mode, led[0]=1 in one-hot mode. Synchroniser, filter and edge registers = 0. FSM enters INIT.
- Synchronisation: two flops per channel (s2_a, s2_b).
- Filter, per channel:
  - A stability counter clears whenever s2 equals the filtered value (f) or s2 changed last cycle.
  - While s2 differs from f and is unchanged, the counter increments.
  - f takes s2 on the edge where the counter reaches FILT_LEN-1, so f follows a clean change FILT_LEN cycles after s2.
  - Pulses shorter than FILT_LEN cycles at s2 never reach f.
- FSM:
  - INIT: lasts 2+FILT_LEN cycles after reset release. f_a and f_b load s2 directly each cycle. No step is generated. Then go to RUN.
  - RUN: normal operation. Returns to INIT only on reset. Reset mid-rotation therefore never produces a spurious step.
- Decode (RUN only): a step is detected when f_a goes 0->1 (f_a=1, f_a_d=0). Direction = f_b at that edge: 0 -> CW, 1 -> CCW. f_a falling edges and f_b edges alone produce nothing.
- Latency: rot_a rises before edge k and stays stable. s2_a=1 at edge k+1, f_a=1 at edge k+1+FILT_LEN. step, dir, count and limit update at edge k+2+FILT_LEN. step is high for exactly one cycle.
- Counter (registered, same edge as step):
  - clr=1: count=0, limit=0, regardless of step or en.
  - step and en=1, CW: count+STEP. CCW: count-STEP.
  - WRAP=1: result is mod 2^CNT_W. limit=1 if the true result is outside [0, 2^CNT_W-1].
  - WRAP=0: result clamps to the range. limit=1 if clamping occurred, including a step attempted while already at the bound.
  - en=0: step and dir still update; count and limit hold/zero.
- LEDs (registered from next count, so they update on the same edge as count):
  - Binary mode: led = count[NUM_LED-1:0].
  - One-hot mode: led = 1<<(count mod NUM_LED).
  - A led_mode change takes effect on the next edge.

Decomposition:
- Package rotary_pkg holds:
  - LED_BIN=1'b0, LED_ONEHOT=1'b1.
  - DIR_CW=1'b0, DIR_CCW=1'b1.
  - The FSM state encoding: ST_INIT, ST_RUN.
- Sub-module rotary_filter (parameter FILT_LEN; ports clk, rst_n, d, init, q) contains the synchroniser and debounce counter. It is instantiated once for A and once for B.

Test Plan (defaults unless stated):
- Reset release with rot_a=1, rot_b=1 held -> no step pulse ever; count=0; led=8'h00.
- Clean CW detent: rot_b=0, rot_a 0->1 held 10 cycles, rising before edge k -> step=1 for one cycle after edge k+6; dir=0; count=1; led=8'h01.
- Glitch: rot_a high for 3 cycles only -> no step; count unchanged.
- Wrap: WRAP=1, count=255, CW step -> count=0, limit pulse. Then CCW step -> count=255, limit pulse.
- Saturate: WRAP=0, STEP=4, count=2, CCW step -> count=0, limit=1. Another CCW step -> count stays 0, limit=1.
- Controls:
  - Step coinciding with clr=1 -> count=0, limit=0.
  - en=0 with a CCW step -> step=1, dir=1, count held.
  - led_mode=1, count=10 -> led=8'b0000_0100.
